// File: rtl/ex_redirect_unit.sv
// ex_redirect_unit: EX-stage branch/jump resolution.
// This unit holds the D->EX branch pipeline register, resolves the branch
// condition and target, and squashes wrong-path instructions after a redirect.
// Optional build macro: BRANCH_STATS_EN adds saturating branch/taken counters.
// Without the macro, br_count and taken_count are tied to 0.
module ex_redirect_unit #(
    parameter int unsigned XLEN         = 5,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PC_STEP      = 1,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_D,
    input  logic              D_valid,
    input  logic              D_is_branch,
    input  logic              D_is_jump,
    input  logic              D_is_jalr,
    input  logic [2:0]        D_funct3,
    input  logic [XLEN-1:0]   D_pc,
    input  logic [DATA_W-1:0] D_imm,
    input  logic [DATA_W-1:0] D_rs1_val,
    input  logic [DATA_W-1:0] D_rs2_val,
    output logic              EX_valid,
    output logic              EX_taken,
    output logic [XLEN-1:0]   EX_alt_pc,
    output logic              EX_flush,
    output logic [XLEN-1:0]   EX_link_pc,
    output logic [15:0]       br_count,
    output logic [15:0]       taken_count
);

    localparam int unsigned KILL_W = 2;
    localparam int unsigned CNT_W  = 16;

    logic              ex_valid_q;
    logic              ex_branch_q;
    logic              ex_jump_q;
    logic              ex_jalr_q;
    logic [2:0]        ex_funct3_q;
    logic [XLEN-1:0]   ex_pc_q;
    logic [DATA_W-1:0] ex_imm_q;
    logic [DATA_W-1:0] ex_rs1_q;
    logic [DATA_W-1:0] ex_rs2_q;
    logic [KILL_W-1:0] kill_cnt;

    logic              cond_c;
    logic              taken_c;
    logic [DATA_W-1:0] pc_sum_c;
    logic [DATA_W-1:0] jalr_sum_c;
    logic [XLEN-1:0]   alt_pc_c;
    logic              unused_sum_bits;

    // EX register: redirect beats stall, stall beats the kill window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_branch_q <= 1'b0;
            ex_jump_q   <= 1'b0;
            ex_jalr_q   <= 1'b0;
            ex_funct3_q <= '0;
            ex_pc_q     <= '0;
            ex_imm_q    <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            kill_cnt    <= '0;
        end else if (taken_c) begin
            ex_valid_q <= 1'b0;
            kill_cnt   <= KILL_W'(FLUSH_CYCLES);
        end else if (stall_D) begin
            ex_valid_q <= 1'b0;
        end else if (kill_cnt != '0) begin
            ex_valid_q <= 1'b0;
            kill_cnt   <= kill_cnt - KILL_W'(1);
        end else begin
            ex_valid_q  <= D_valid;
            ex_branch_q <= D_is_branch;
            ex_jump_q   <= D_is_jump;
            ex_jalr_q   <= D_is_jalr;
            ex_funct3_q <= D_funct3;
            ex_pc_q     <= D_pc;
            ex_imm_q    <= D_imm;
            ex_rs1_q    <= D_rs1_val;
            ex_rs2_q    <= D_rs2_val;
        end
    end

    // Branch condition evaluation on the captured operands
    always_comb begin
        cond_c = 1'b0;
        case (ex_funct3_q)
            3'b000:  cond_c = (ex_rs1_q == ex_rs2_q);
            3'b001:  cond_c = (ex_rs1_q != ex_rs2_q);
            3'b100:  cond_c = ($signed(ex_rs1_q) <  $signed(ex_rs2_q));
            3'b101:  cond_c = ($signed(ex_rs1_q) >= $signed(ex_rs2_q));
            3'b110:  cond_c = (ex_rs1_q <  ex_rs2_q);
            3'b111:  cond_c = (ex_rs1_q >= ex_rs2_q);
            default: cond_c = 1'b0;
        endcase
    end

    // Target adders; only the low XLEN bits reach the fetch PC
    assign pc_sum_c   = DATA_W'(ex_pc_q) + ex_imm_q;
    assign jalr_sum_c = ex_rs1_q + ex_imm_q;
    assign unused_sum_bits = ^{pc_sum_c, jalr_sum_c};

    assign taken_c = ex_valid_q & (ex_jump_q | ex_jalr_q | (ex_branch_q & cond_c));

    // Redirect target with jalr > jump > branch precedence
    always_comb begin
        alt_pc_c = '0;
        if (taken_c) begin
            if (ex_jalr_q) begin
                alt_pc_c = jalr_sum_c[XLEN-1:0];
            end else begin
                alt_pc_c = pc_sum_c[XLEN-1:0];
            end
        end
    end

    assign EX_valid   = ex_valid_q;
    assign EX_taken   = taken_c;
    assign EX_flush   = taken_c;
    assign EX_alt_pc  = alt_pc_c;
    assign EX_link_pc = ex_pc_q + XLEN'(PC_STEP);

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] taken_cnt_q;

    // Saturating statistics for resolved and taken control transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            if (ex_valid_q && (ex_branch_q || ex_jump_q || ex_jalr_q) &&
                (br_cnt_q != {CNT_W{1'b1}})) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (taken_c && (taken_cnt_q != {CNT_W{1'b1}})) begin
                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign br_count    = br_cnt_q;
    assign taken_count = taken_cnt_q;
`else
    assign br_count    = '0;
    assign taken_count = '0;
`endif

endmodule

// File: tb/tb_ex_redirect_unit.sv
// tb_ex_redirect_unit: scoreboard bench for ex_redirect_unit (XLEN=5, FLUSH_CYCLES=1).
module tb_ex_redirect_unit;

    localparam int unsigned XLEN    = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PC_STEP = 1;
    localparam int unsigned FLUSH   = 1;

    logic              clk;
    logic              rst;
    logic              stall_D;
    logic              D_valid;
    logic              D_is_branch;
    logic              D_is_jump;
    logic              D_is_jalr;
    logic [2:0]        D_funct3;
    logic [XLEN-1:0]   D_pc;
    logic [DATA_W-1:0] D_imm;
    logic [DATA_W-1:0] D_rs1_val;
    logic [DATA_W-1:0] D_rs2_val;
    logic              EX_valid;
    logic              EX_taken;
    logic [XLEN-1:0]   EX_alt_pc;
    logic              EX_flush;
    logic [XLEN-1:0]   EX_link_pc;
    logic [15:0]       br_count;
    logic [15:0]       taken_count;

    ex_redirect_unit #(
        .XLEN(XLEN), .DATA_W(DATA_W), .PC_STEP(PC_STEP), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk), .rst(rst), .stall_D(stall_D), .D_valid(D_valid),
        .D_is_branch(D_is_branch), .D_is_jump(D_is_jump), .D_is_jalr(D_is_jalr),
        .D_funct3(D_funct3), .D_pc(D_pc), .D_imm(D_imm),
        .D_rs1_val(D_rs1_val), .D_rs2_val(D_rs2_val),
        .EX_valid(EX_valid), .EX_taken(EX_taken), .EX_alt_pc(EX_alt_pc),
        .EX_flush(EX_flush), .EX_link_pc(EX_link_pc),
        .br_count(br_count), .taken_count(taken_count)
    );

    typedef struct {
        logic            valid;
        logic            taken;
        logic [XLEN-1:0] alt;
        logic [XLEN-1:0] link;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic            m_taken;
    int              m_kill;
    logic [XLEN-1:0] m_link;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, ".valid"}, 32'(EX_valid),   32'd0);
        check({tag, ".taken"}, 32'(EX_taken),   32'd0);
        check({tag, ".flush"}, 32'(EX_flush),   32'd0);
        check({tag, ".alt"},   32'(EX_alt_pc),  32'd0);
        check({tag, ".link"},  32'(EX_link_pc), 32'(PC_STEP));
        check({tag, ".brcnt"}, 32'(br_count),   32'd0);
        check({tag, ".tkcnt"}, 32'(taken_count),32'd0);
        @(negedge clk);
        rst     = 1'b0;
        m_taken = 1'b0;
        m_kill  = 0;
        m_link  = XLEN'(PC_STEP);
    endtask

    task automatic step(input string tag, input logic stall, input logic dv,
                        input logic b, input logic j, input logic jr,
                        input logic [2:0] f3, input logic [XLEN-1:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t e;
        exp_t got_e;
        @(negedge clk);
        stall_D = stall; D_valid = dv; D_is_branch = b; D_is_jump = j; D_is_jalr = jr;
        D_funct3 = f3; D_pc = pc; D_imm = imm; D_rs1_val = rs1; D_rs2_val = rs2;
        e.valid = 1'b0; e.taken = 1'b0; e.alt = '0;
        if (m_taken) begin
            m_kill = FLUSH;
        end else if (stall) begin
            m_kill = m_kill;
        end else if (m_kill != 0) begin
            m_kill = m_kill - 1;
        end else begin
            e.valid = dv;
            e.taken = dv & (j | jr | (b & ref_cond(f3, rs1, rs2)));
            if (e.taken) e.alt = jr ? XLEN'(rs1 + imm) : XLEN'(32'(pc) + imm);
            m_link = pc + XLEN'(PC_STEP);
        end
        e.link  = m_link;
        m_taken = e.taken;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb.pop_front();
        check({tag, ".valid"}, 32'(EX_valid),   32'(got_e.valid));
        check({tag, ".taken"}, 32'(EX_taken),   32'(got_e.taken));
        check({tag, ".flush"}, 32'(EX_flush),   32'(got_e.taken));
        check({tag, ".alt"},   32'(EX_alt_pc),  32'(got_e.alt));
        check({tag, ".link"},  32'(EX_link_pc), 32'(got_e.link));
    endtask

    // Fixed expectations from the plan, cross-checking the model
    task automatic fixed(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check(tag, got, exp);
    endtask

    initial begin
        rst = 1'b1; stall_D = 0; D_valid = 0; D_is_branch = 0; D_is_jump = 0; D_is_jalr = 0;
        D_funct3 = 0; D_pc = 0; D_imm = 0; D_rs1_val = 0; D_rs2_val = 0;
        m_taken = 0; m_kill = 0; m_link = XLEN'(PC_STEP);
        #12;
        do_reset("rst0");

        // BEQ taken, two squashed advances, third captured
        step("beq",   0, 1, 1, 0, 0, 3'd0, 5'd4, 32'd6, 32'd9, 32'd9);
        fixed("beq.alt10", 32'(EX_alt_pc), 32'd10);
        step("sq1",   0, 1, 0, 1, 0, 3'd0, 5'd7, 32'd1, 32'd0, 32'd0);
        step("sq2",   0, 1, 0, 1, 0, 3'd0, 5'd8, 32'd1, 32'd0, 32'd0);
        step("bne_nt",0, 1, 1, 0, 0, 3'd1, 5'd2, 32'd3, 32'd1, 32'd1);
        fixed("bne_nt.valid", 32'(EX_valid), 32'd1);

        // Signed vs unsigned compare
        step("blt",   0, 1, 1, 0, 0, 3'd4, 5'd8, 32'd2, 32'hFFFFFFFF, 32'd1);
        step("sq3",   0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("sq4",   0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("bltu",  0, 1, 1, 0, 0, 3'd6, 5'd8, 32'd2, 32'hFFFFFFFF, 32'd1);
        step("bgeu",  0, 1, 1, 0, 0, 3'd7, 5'd9, 32'd2, 32'd1, 32'hFFFFFFFF);
        step("f010",  0, 1, 1, 0, 0, 3'd2, 5'd9, 32'd2, 32'd5, 32'd5);
        step("f011",  0, 1, 1, 0, 0, 3'd3, 5'd9, 32'd2, 32'd5, 32'd5);
        step("bge",   0, 1, 1, 0, 0, 3'd5, 5'd1, 32'd3, 32'd1, 32'hFFFFFFFF);
        step("sq5",   0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("sq6",   0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // JALR wrap and JAL link wrap
        step("jalr",  0, 1, 0, 0, 1, 3'd0, 5'd6, 32'd5, 32'd30, 32'd0);
        fixed("jalr.alt3", 32'(EX_alt_pc), 32'd3);
        step("sq7",   0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("sq8",   0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("jal",   0, 1, 0, 1, 0, 3'd0, 5'd31, 32'd2, 32'd0, 32'd0);
        fixed("jal.link0", 32'(EX_link_pc), 32'd0);
        step("sq9",   0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("sq10",  0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // Invalid jump never redirects, no kill window follows
        step("inv_j", 0, 0, 0, 1, 0, 3'd0, 5'd5, 32'd4, 32'd0, 32'd0);
        step("after_inv", 0, 1, 1, 0, 0, 3'd1, 5'd6, 32'd4, 32'd1, 32'd1);

        // All type flags: jalr target wins
        step("prec",  0, 1, 1, 1, 1, 3'd0, 5'd3, 32'd4, 32'd20, 32'd20);
        step("sq11",  0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("sq12",  0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // Redirect with stall, stalls extend window, then squash then capture
        step("beq2",  0, 1, 1, 0, 0, 3'd0, 5'd4, 32'd6, 32'd9, 32'd9);
        step("st1",   1, 1, 1, 0, 0, 3'd1, 5'd10, 32'd1, 32'd1, 32'd2);
        step("st2",   1, 1, 1, 0, 0, 3'd1, 5'd10, 32'd1, 32'd1, 32'd2);
        step("st3",   1, 1, 1, 0, 0, 3'd1, 5'd10, 32'd1, 32'd1, 32'd2);
        step("st_sq", 0, 1, 1, 0, 0, 3'd1, 5'd10, 32'd1, 32'd1, 32'd1);
        fixed("st_sq.valid", 32'(EX_valid), 32'd0);
        step("st_cap",0, 1, 1, 0, 0, 3'd1, 5'd11, 32'd1, 32'd1, 32'd1);
        fixed("st_cap.valid", 32'(EX_valid), 32'd1);

        // Reset inside the kill window abandons it
        step("beq3",  0, 1, 1, 0, 0, 3'd0, 5'd4, 32'd6, 32'd9, 32'd9);
        step("st4",   1, 1, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        #2;
        do_reset("rst_win");
        step("post_rst", 0, 1, 1, 0, 0, 3'd1, 5'd12, 32'd1, 32'd3, 32'd3);
        fixed("post_rst.valid", 32'(EX_valid), 32'd1);

        // Statistics: 5 branches (2 taken) and 1 JAL
        #2;
        do_reset("rst_cnt");
        step("c_b1",  0, 1, 1, 0, 0, 3'd1, 5'd1, 32'd1, 32'd1, 32'd1);
        step("c_b2",  0, 1, 1, 0, 0, 3'd0, 5'd2, 32'd1, 32'd1, 32'd2);
        step("c_b3",  0, 1, 1, 0, 0, 3'd6, 5'd3, 32'd1, 32'd1, 32'd0);
        step("c_b4",  0, 1, 1, 0, 0, 3'd0, 5'd4, 32'd1, 32'd7, 32'd7);
        step("c_n1",  0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("c_n2",  0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("c_b5",  0, 1, 1, 0, 0, 3'd1, 5'd5, 32'd1, 32'd1, 32'd2);
        step("c_n3",  0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("c_n4",  0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("c_j",   0, 1, 0, 1, 0, 3'd0, 5'd6, 32'd1, 32'd0, 32'd0);
        step("c_n5",  0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step("c_n6",  0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
`ifdef BRANCH_STATS_EN
        fixed("br_count",    32'(br_count),    32'd6);
        fixed("taken_count", 32'(taken_count), 32'd3);
`else
        fixed("br_count",    32'(br_count),    32'd0);
        fixed("taken_count", 32'(taken_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
